// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: latch enables, bubble strobes, halt and DWAIT watchdog.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int DWAIT_MAX = 64,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             br_taken,
    input  logic             halt_wb,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             wait_err,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int WW = $clog2(DWAIT_MAX + 1);

    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] wcnt;

    logic load_use;
    logic stop;
    logic dstall;
    logic apply_br;
    logic apply_lu;
    logic apply_is;

    assign load_use = idex_memread && (idex_rt != 5'd0)
                   && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Mutually exclusive events, resolved in priority order
    assign stop     = (state == HALTED) || halt_wb;
    assign dstall   = !stop && mem_req && !dhit;
    assign apply_br = !stop && !dstall && br_taken;
    assign apply_lu = !stop && !dstall && !br_taken && load_use;
    assign apply_is = !stop && !dstall && !br_taken && !load_use && !ihit;

    assign halted = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = HALTED;
        end else begin
            unique case (state)
                RUN:     if (mem_req && !dhit) state_nx = DWAIT;
                DWAIT:   if (dhit) state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    always_comb begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!RST) begin
            unique case (1'b1)
                stop, dstall: begin
                end
                apply_br: begin
                    pc_wen      = 1'b1;
                    ifid_wen    = 1'b1;
                    idex_wen    = 1'b1;
                    exmem_wen   = 1'b1;
                    memwb_wen   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end
                apply_lu: begin
                    idex_wen   = 1'b1;
                    exmem_wen  = 1'b1;
                    memwb_wen  = 1'b1;
                    idex_flush = 1'b1;
                end
                apply_is: begin
                    ifid_wen   = 1'b1;
                    idex_wen   = 1'b1;
                    exmem_wen  = 1'b1;
                    memwb_wen  = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: begin
                    pc_wen    = 1'b1;
                    ifid_wen  = 1'b1;
                    idex_wen  = 1'b1;
                    exmem_wen = 1'b1;
                    memwb_wen = 1'b1;
                end
            endcase
        end
    end

    // Watchdog counts unanswered DWAIT cycles and saturates at DWAIT_MAX
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt     <= '0;
            wait_err <= 1'b0;
        end else if (state == DWAIT && !dhit && !halt_wb) begin
            if (wcnt != WW'(DWAIT_MAX)) wcnt <= wcnt + WW'(1);
            if (wcnt >= WW'(DWAIT_MAX - 1)) wait_err <= 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dstall_cnt <= '0;
            istall_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (dstall)   dstall_cnt <= dstall_cnt + CNT_W'(1);
            if (apply_is) istall_cnt <= istall_cnt + CNT_W'(1);
            if (apply_br) flush_cnt  <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign dstall_cnt = '0;
    assign istall_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (DWAIT_MAX reduced to 4).
// Inputs change 1ns after a rising edge; outputs are sampled 4ns after it.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc, ifid, idex, exmem, memwb wen, ifid, idex, exmem flush}
    localparam logic [7:0] DEF = 8'b11111_000;
    localparam logic [7:0] FRZ = 8'b00000_000;
    localparam logic [7:0] BRF = 8'b11111_111;
    localparam logic [7:0] LUS = 8'b00111_010;
    localparam logic [7:0] IST = 8'b01111_100;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, mem_req, idex_memread, br_taken, halt_wb;
    logic [4:0]       idex_rt, ifid_rs, ifid_rt;
    logic             pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic             ifid_flush, idex_flush, exmem_flush, halted, wait_err;
    logic [CNT_W-1:0] dstall_cnt, istall_cnt, flush_cnt;
    logic [7:0]       ctl;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.DWAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt), .br_taken(br_taken), .halt_wb(halt_wb),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
        .wait_err(wait_err), .dstall_cnt(dstall_cnt), .istall_cnt(istall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctl = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                  ifid_flush, idex_flush, exmem_flush};

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; idex_memread = 1'b0;
        br_taken = 1'b0; halt_wb = 1'b0;
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #1 RST = 1'b1;
        next();
        RST = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        #2;
        checks++;
        if (ctl !== FRZ || halted !== 1'b0 || wait_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_init ctl=%b halted=%b werr=%b want ctl=%b 0 0",
                     ctl, halted, wait_err, FRZ);
        end
        next();
        RST = 1'b0;
        mem_req = 1'b1;
        next();
        next();
        #3;
        checks++;
        if (ctl !== FRZ) begin
            failures++;
            $display("FAIL dwait_before_rst ctl=%b want %b", ctl, FRZ);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (ctl !== FRZ || halted !== 1'b0 || wait_err !== 1'b0 ||
            dstall_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset ctl=%b halted=%b werr=%b dcnt=%0d want all 0",
                     ctl, halted, wait_err, dstall_cnt);
        end
        next();
        RST = 1'b0;
        idle();
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL after_reset ctl=%b want %b", ctl, DEF);
        end
    endtask

    task automatic test_dstall();
        next();
        mem_req = 1'b1;
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (ctl !== FRZ) begin
                failures++;
                $display("FAIL dstall_c%0d ctl=%b want %b", i, ctl, FRZ);
            end
            next();
        end
        dhit = 1'b1;
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL dstall_release ctl=%b want %b", ctl, DEF);
        end
        next();
        idle();
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL dstall_after ctl=%b want %b", ctl, DEF);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (dstall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL dstall_cnt got %0d want 3", dstall_cnt);
        end
`else
        checks++;
        if (dstall_cnt !== '0) begin
            failures++;
            $display("FAIL dstall_cnt_off got %0d want 0", dstall_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        next();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
        #3;
        checks++;
        if (ctl !== LUS) begin
            failures++;
            $display("FAIL lu_rs ctl=%b want %b", ctl, LUS);
        end
        next();
        idex_rt = 5'd7; ifid_rs = 5'd1; ifid_rt = 5'd7;
        #3;
        checks++;
        if (ctl !== LUS) begin
            failures++;
            $display("FAIL lu_rt ctl=%b want %b", ctl, LUS);
        end
        next();
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL lu_r0 ctl=%b want %b", ctl, DEF);
        end
        next();
        idex_rt = 5'd5; ifid_rs = 5'd6; ifid_rt = 5'd4;
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL lu_nomatch ctl=%b want %b", ctl, DEF);
        end
        next();
        idle();
    endtask

    task automatic test_branch_freeze();
        next();
        br_taken = 1'b1; mem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++;
            if (ctl !== FRZ) begin
                failures++;
                $display("FAIL br_frozen_c%0d ctl=%b want %b", i, ctl, FRZ);
            end
            next();
        end
        dhit = 1'b1;
        #3;
        checks++;
        if (ctl !== BRF) begin
            failures++;
            $display("FAIL br_release ctl=%b want %b", ctl, BRF);
        end
        next();
        idle();
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL br_once ctl=%b want %b", ctl, DEF);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (flush_cnt !== 32'd1 || dstall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL br_counts flush=%0d dstall=%0d want 1 5",
                     flush_cnt, dstall_cnt);
        end
`endif
    endtask

    task automatic test_lu_istall();
        next();
        ihit = 1'b0; idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
        #3;
        checks++;
        if (ctl !== LUS) begin
            failures++;
            $display("FAIL lu_istall ctl=%b want %b", ctl, LUS);
        end
        next();
        idex_memread = 1'b0;
        #3;
        checks++;
        if (ctl !== IST) begin
            failures++;
            $display("FAIL istall ctl=%b want %b", ctl, IST);
        end
        next();
        idle();
        #3;
        checks++;
        if (ctl !== DEF) begin
            failures++;
            $display("FAIL istall_after ctl=%b want %b", ctl, DEF);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (istall_cnt !== 32'd1) begin
            failures++;
            $display("FAIL istall_cnt got %0d want 1", istall_cnt);
        end
`endif
    endtask

    task automatic test_halt();
        next();
        halt_wb = 1'b1;
        #3;
        checks++;
        if (ctl !== FRZ || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_cycle ctl=%b halted=%b want %b 0", ctl, halted, FRZ);
        end
        next();
        halt_wb = 1'b0; ihit = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (ctl !== FRZ || halted !== 1'b1) begin
                failures++;
                $display("FAIL halted_c%0d ctl=%b halted=%b want %b 1",
                         i, ctl, halted, FRZ);
            end
            next();
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (istall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
            failures++;
            $display("FAIL halt_freeze istall=%0d flush=%0d want 1 1",
                     istall_cnt, flush_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_watchdog();
        next();
        mem_req = 1'b1; dhit = 1'b0;
        next();
        for (int i = 1; i <= 4; i++) begin
            #3;
            checks++;
            if (wait_err !== 1'b0 || ctl !== FRZ) begin
                failures++;
                $display("FAIL wd_pre_c%0d werr=%b ctl=%b want 0 %b",
                         i, wait_err, ctl, FRZ);
            end
            next();
        end
        #3;
        checks++;
        if (wait_err !== 1'b1) begin
            failures++;
            $display("FAIL wd_set werr=%b want 1", wait_err);
        end
        next();
        dhit = 1'b1;
        next();
        idle();
        next();
        #3;
        checks++;
        if (wait_err !== 1'b1 || ctl !== DEF) begin
            failures++;
            $display("FAIL wd_sticky werr=%b ctl=%b want 1 %b", wait_err, ctl, DEF);
        end
    endtask

    initial begin
        test_reset();
        test_dstall();
        test_load_use();
        test_branch_freeze();
        test_lu_istall();
        test_halt();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
